// File: rtl/matvec_ntt_mac.sv
// NTT-domain matrix-vector product w_hat[i][n] = sum_j A_hat[i][j][n] * y_hat[j][n] mod q.
// One coefficient product per cycle: operand fetch, multiply, reduce, accumulate.
module matvec_ntt_mac #(
    parameter int K           = 8,
    parameter int L           = 7,
    parameter int N           = 256,
    parameter int COEFF_WIDTH = 24,
    parameter int Q           = 8380417
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic [K-1:0][L-1:0][N-1:0][COEFF_WIDTH-1:0] matA,
    input  logic [L-1:0][N-1:0][COEFF_WIDTH-1:0]        vecY,
    output logic                                        busy,
    output logic                                        done,
    output logic [K-1:0][N-1:0][COEFF_WIDTH-1:0]        w_hat,
    output logic [1:0]                                  dbg_state
);
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam int JW = (L > 1) ? $clog2(L) : 1;
    localparam int NW = $clog2(N);
    localparam logic [23:0] QV = 24'(Q);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] i_cnt;
    logic [JW-1:0] j_cnt;
    logic [NW-1:0] n_cnt;
    logic [1:0]    drain_cnt;
    logic          accept;
    logic          last_issue;

    // Handshake: start is a one-cycle request taken only while idle (busy=0);
    // busy stays high through the done cycle, so any start seen with busy=1 is dropped.
    assign accept     = (state == IDLE) && start;
    assign last_issue = (state == RUN) && (i_cnt == IW'(K - 1)) &&
                        (j_cnt == JW'(L - 1)) && (n_cnt == NW'(N - 1));
    assign dbg_state  = state;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_issue) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == 2'd3) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            drain_cnt <= 2'd0;
            i_cnt     <= '0;
            j_cnt     <= '0;
            n_cnt     <= '0;
        end else begin
            state     <= state_nxt;
            busy      <= (state_nxt != IDLE);
            done      <= (state_nxt == DONE);
            drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
            if (accept) begin
                i_cnt <= '0;
                j_cnt <= '0;
                n_cnt <= '0;
            end else if (state == RUN) begin
                if (n_cnt == NW'(N - 1)) begin
                    n_cnt <= '0;
                    if (j_cnt == JW'(L - 1)) begin
                        j_cnt <= '0;
                        i_cnt <= i_cnt + IW'(1);
                    end else begin
                        j_cnt <= j_cnt + JW'(1);
                    end
                end else begin
                    n_cnt <= n_cnt + NW'(1);
                end
            end
        end
    end

    // Pipeline: s0 operands, s1 raw product, s2 reduced product, then writeback.
    logic          s0_v, s1_v, s2_v;
    logic [22:0]   s0_a, s0_b;
    logic [45:0]   s1_prod;
    logic [22:0]   s2_p;
    logic [IW-1:0] s0_i, s1_i, s2_i;
    logic [NW-1:0] s0_n, s1_n, s2_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_v <= 1'b0;
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else begin
            s0_v <= (state == RUN);
            s1_v <= s0_v;
            s2_v <= s1_v;
        end
    end

    // Reduction folds with 2^23 = 2^13 - 1 (mod q); the constants are specific to q = 8380417.
    logic [36:0] r1;
    logic [27:0] r2;
    logic [23:0] r3;
    logic [22:0] p_red;
    logic [22:0] acc_old;
    logic [23:0] acc_sum;
    logic [22:0] acc_new;

    always_comb begin
        r1      = 37'(s1_prod[45:23]) * 37'd8191 + 37'(s1_prod[22:0]);
        r2      = 28'(r1[36:23]) * 28'd8191 + 28'(r1[22:0]);
        r3      = 24'(r2[27:23]) * 24'd8191 + 24'(r2[22:0]);
        p_red   = (r3 >= QV) ? 23'(r3 - QV) : r3[22:0];
        acc_old = w_hat[s2_i][s2_n][22:0];
        acc_sum = {1'b0, acc_old} + {1'b0, s2_p};
        acc_new = (acc_sum >= QV) ? 23'(acc_sum - QV) : acc_sum[22:0];
    end

    always_ff @(posedge clk) begin
        s0_a    <= matA[i_cnt][j_cnt][n_cnt][22:0];
        s0_b    <= vecY[j_cnt][n_cnt][22:0];
        s0_i    <= i_cnt;
        s0_n    <= n_cnt;
        s1_prod <= 46'(s0_a) * 46'(s0_b);
        s1_i    <= s0_i;
        s1_n    <= s0_n;
        s2_p    <= p_red;
        s2_i    <= s1_i;
        s2_n    <= s1_n;
    end

    // A slot is revisited only every N issues, so the read-modify-write never sees stale data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_hat <= '0;
        end else if (accept) begin
            w_hat <= '0;
        end else if (s2_v) begin
            w_hat[s2_i][s2_n] <= {1'b1, acc_new};
        end
    end

endmodule

// File: tb/tb_matvec_ntt_mac.sv
// Self-checking bench for matvec_ntt_mac: a small 2x2x8 instance and a default-size instance.
module tb_matvec_ntt_mac;
    localparam int CW = 24;
    localparam int Q  = 8380417;
    localparam int SK = 2, SL = 2, SN = 8;
    localparam int BK = 8, BL = 7, BN = 256;

    logic clk = 1'b0;
    logic rst;
    logic start_s, start_b;
    logic busy_s, done_s, busy_b, done_b;
    logic [1:0] dbg_s, dbg_b;
    logic [SK-1:0][SL-1:0][SN-1:0][CW-1:0] mat_s;
    logic [SL-1:0][SN-1:0][CW-1:0]         vec_s;
    logic [SK-1:0][SN-1:0][CW-1:0]         w_s;
    logic [BK-1:0][BL-1:0][BN-1:0][CW-1:0] mat_b;
    logic [BL-1:0][BN-1:0][CW-1:0]         vec_b;
    logic [BK-1:0][BN-1:0][CW-1:0]         w_b;

    int unsigned a_s[SK][SL][SN];
    int unsigned y_s[SL][SN];
    int unsigned a_b[BK][BL][BN];
    int unsigned y_b[BL][BN];
    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    matvec_ntt_mac #(.K(SK), .L(SL), .N(SN), .COEFF_WIDTH(CW), .Q(Q)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .matA(mat_s), .vecY(vec_s),
        .busy(busy_s), .done(done_s), .w_hat(w_s), .dbg_state(dbg_s)
    );

    matvec_ntt_mac dut_b (
        .clk(clk), .rst(rst), .start(start_b), .matA(mat_b), .vecY(vec_b),
        .busy(busy_b), .done(done_b), .w_hat(w_b), .dbg_state(dbg_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain modular sum of products over the columns.
    function automatic int unsigned model_s(int i, int n);
        longint acc = 0;
        for (int j = 0; j < SL; j++)
            acc = (acc + longint'(a_s[i][j][n]) * longint'(y_s[j][n])) % Q;
        return int'(acc);
    endfunction

    function automatic int unsigned model_b(int i, int n);
        longint acc = 0;
        for (int j = 0; j < BL; j++)
            acc = (acc + longint'(a_b[i][j][n]) * longint'(y_b[j][n])) % Q;
        return int'(acc);
    endfunction

    function automatic logic cur_done(input bit big);
        return big ? done_b : done_s;
    endfunction

    function automatic logic cur_busy(input bit big);
        return big ? busy_b : busy_s;
    endfunction

    function automatic int nz_s();
        int c = 0;
        for (int i = 0; i < SK; i++)
            for (int n = 0; n < SN; n++)
                if (w_s[i][n] !== '0) c++;
        return c;
    endfunction

    function automatic int nz_b();
        int c = 0;
        for (int i = 0; i < BK; i++)
            for (int n = 0; n < BN; n++)
                if (w_b[i][n] !== '0) c++;
        return c;
    endfunction

    task automatic pack_s(input bit noise);
        for (int i = 0; i < SK; i++)
            for (int j = 0; j < SL; j++)
                for (int n = 0; n < SN; n++)
                    mat_s[i][j][n] = {noise ? 1'($urandom_range(1, 0)) : 1'b0, 23'(a_s[i][j][n])};
        for (int j = 0; j < SL; j++)
            for (int n = 0; n < SN; n++)
                vec_s[j][n] = {noise ? 1'($urandom_range(1, 0)) : 1'b0, 23'(y_s[j][n])};
    endtask

    task automatic pack_b();
        for (int i = 0; i < BK; i++)
            for (int j = 0; j < BL; j++)
                for (int n = 0; n < BN; n++)
                    mat_b[i][j][n] = {1'($urandom_range(1, 0)), 23'(a_b[i][j][n])};
        for (int j = 0; j < BL; j++)
            for (int n = 0; n < BN; n++)
                vec_b[j][n] = {1'($urandom_range(1, 0)), 23'(y_b[j][n])};
    endtask

    task automatic rand_s();
        for (int i = 0; i < SK; i++)
            for (int j = 0; j < SL; j++)
                for (int n = 0; n < SN; n++) a_s[i][j][n] = $urandom_range(Q - 1, 0);
        for (int j = 0; j < SL; j++)
            for (int n = 0; n < SN; n++) y_s[j][n] = $urandom_range(Q - 1, 0);
    endtask

    task automatic check_s(input string tag);
        for (int i = 0; i < SK; i++)
            for (int n = 0; n < SN; n++)
                check($sformatf("%s w[%0d][%0d]", tag, i, n), 64'(w_s[i][n]),
                      64'({1'b1, 23'(model_s(i, n))}));
    endtask

    task automatic check_b(input string tag);
        int bi = BK - 1, bn = BN - 1, bad = 0;
        for (int i = 0; i < BK; i++)
            for (int n = 0; n < BN; n++)
                if (w_b[i][n] !== {1'b1, 23'(model_b(i, n))}) begin
                    if (bad == 0) begin bi = i; bn = n; end
                    bad++;
                end
        check($sformatf("%s w[%0d][%0d] (%0d slots off)", tag, bi, bn, bad), 64'(w_b[bi][bn]),
              64'({1'b1, 23'(model_b(bi, bn))}));
    endtask

    // Starts a product, optionally re-pulses start at cycle poke_cyc, and checks the handshake.
    task automatic run(input bit big, input int poke_cyc, input int exp_lat, input string tag);
        int cyc = 0, busy_low = 0, extra = 0;
        bit got_done = 1'b0;
        @(negedge clk);
        if (big) start_b = 1'b1; else start_s = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        start_s = 1'b0;
        check({tag, " busy after start"}, 64'(cur_busy(big)), 64'd1);
        while (!got_done && cyc < exp_lat + 100) begin
            @(posedge clk); #1;
            cyc++;
            if (cur_busy(big) !== 1'b1) busy_low++;
            got_done = cur_done(big);
            if (big) start_b = (cyc == poke_cyc); else start_s = (cyc == poke_cyc);
        end
        start_b = 1'b0;
        start_s = 1'b0;
        check({tag, " done seen"}, 64'(got_done), 64'd1);
        check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, " busy held"}, 64'(busy_low), 64'd0);
        @(posedge clk); #1;
        check({tag, " done one cycle"}, 64'(cur_done(big)), 64'd0);
        check({tag, " busy cleared"}, 64'(cur_busy(big)), 64'd0);
        repeat (40) begin
            @(posedge clk); #1;
            if (cur_done(big) !== 1'b0) extra++;
        end
        check({tag, " no extra done"}, 64'(extra), 64'd0);
    endtask

    initial begin
        rst     = 1'b0;
        start_s = 1'b0;
        start_b = 1'b0;
        mat_s   = '0;
        vec_s   = '0;
        #12;
        check("reset done_s", 64'(done_s), 64'd0);
        check("reset busy_s", 64'(busy_s), 64'd0);
        check("reset w_s", 64'(nz_s()), 64'd0);
        check("reset done_b", 64'(done_b), 64'd0);
        check("reset busy_b", 64'(busy_b), 64'd0);
        check("reset w_b", 64'(nz_b()), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Ones matrix, y[j][n] = n: every result slot is 2n.
        for (int i = 0; i < SK; i++)
            for (int j = 0; j < SL; j++)
                for (int n = 0; n < SN; n++) a_s[i][j][n] = 1;
        for (int j = 0; j < SL; j++)
            for (int n = 0; n < SN; n++) y_s[j][n] = n;
        pack_s(1'b0);
        run(1'b0, -1, 36, "ones");
        check_s("ones");

        pack_s(1'b1);
        run(1'b0, -1, 36, "ones masked");
        check_s("ones masked");

        // Row 0: (q-1)*1 + 2*1 forces the conditional subtract; row 1 random.
        rand_s();
        for (int n = 0; n < SN; n++) begin
            a_s[0][0][n] = Q - 1;
            a_s[0][1][n] = 2;
            y_s[0][n]    = 1;
            y_s[1][n]    = 1;
        end
        pack_s(1'b0);
        run(1'b0, -1, 36, "modadd");
        check_s("modadd");

        rand_s();
        pack_s(1'b1);
        run(1'b0, 10, 36, "start while busy");
        check_s("start while busy");

        for (int r = 0; r < 2; r++) begin
            rand_s();
            pack_s(1'b1);
            run(1'b0, -1, 36, $sformatf("random%0d", r));
            check_s($sformatf("random%0d", r));
        end

        // Default size, all slots q-1: each product is 1, each result 7.
        for (int i = 0; i < BK; i++)
            for (int j = 0; j < BL; j++)
                for (int n = 0; n < BN; n++) a_b[i][j][n] = Q - 1;
        for (int j = 0; j < BL; j++)
            for (int n = 0; n < BN; n++) y_b[j][n] = Q - 1;
        pack_b();
        run(1'b1, -1, 14340, "wrap");
        check_b("wrap");

        // Reset 100 cycles into a default-size run, then a clean rerun.
        for (int i = 0; i < BK; i++)
            for (int j = 0; j < BL; j++)
                for (int n = 0; n < BN; n++) a_b[i][j][n] = $urandom_range(Q - 1, 0);
        for (int j = 0; j < BL; j++)
            for (int n = 0; n < BN; n++) y_b[j][n] = $urandom_range(Q - 1, 0);
        pack_b();
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("midrun busy", 64'(busy_b), 64'd1);
        check("midrun partial writes", 64'(nz_b() != 0), 64'd1);
        rst = 1'b0;
        #1;
        check("midrun rst done", 64'(done_b), 64'd0);
        check("midrun rst busy", 64'(busy_b), 64'd0);
        check("midrun rst w_b", 64'(nz_b()), 64'd0);
        check("midrun rst w_s", 64'(nz_s()), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        run(1'b1, -1, 14340, "after reset");
        check_b("after reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
